sc_game_status: RTL and testbench

//  Holds the persistent game state consumed and produced by the principal game FSM:

---
 rtl/sc_game_status.sv | 167 ++++++++++++++++
 tb/tb_sc_game_status.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sc_game_status.sv
// -----------------------------------------------------------------------------
// sc_game_status
// Persistent game state for the principal game FSM: lives, level and the
// houses-occupied register. It consumes the FSM's event pulses and codes and
// returns the updated counters on the next cycle. It also drives respawn,
// game-over and win flags to the display and frog blocks.
//
// Ports
//   SC_GAMESTATUS_CLOCK_50      in   1  system clock, rising edge
//   SC_GAMESTATUS_RESET_InHigh  in   1  asynchronous reset, active high
//   SC_GAMESTATUS_LIVEDEC       in   1  life-lost pulse
//   SC_GAMESTATUS_LEVELINC      in   1  level-passed pulse
//   SC_GAMESTATUS_LEVELOR       in   8  next houses value
//   SC_GAMESTATUS_RESETLEVEL    in   3  0 none, 1 life lost, 2 game lost
//   SC_GAMESTATUS_NEXTLEVEL     in   4  0 none, 1 house taken, 2 next level, 3 game won
//   SC_GAMESTATUS_LIVECOUNT     out  4  remaining lives
//   SC_GAMESTATUS_LEVELCOUNT    out  4  current level index
//   SC_GAMESTATUS_HOUSES        out  8  occupied houses, one bit per house
//   SC_GAMESTATUS_SPEEDSEL      out  2  traffic speed select (level[1:0])
//   SC_GAMESTATUS_RESPAWN       out  1  one-cycle frog respawn pulse
//   SC_GAMESTATUS_GAMEOVER      out  1  sticky lose flag
//   SC_GAMESTATUS_GAMEWIN       out  1  sticky win flag
// -----------------------------------------------------------------------------
module sc_game_status #(
    parameter int unsigned INIT_LIVES     = 3,
    parameter int unsigned MAX_LEVEL      = 3,
    parameter int unsigned HOLDOFF_CYCLES = 1000000,
    parameter int unsigned HOLDOFF_W      = 20
) (
    input  logic       SC_GAMESTATUS_CLOCK_50,
    input  logic       SC_GAMESTATUS_RESET_InHigh,
    input  logic       SC_GAMESTATUS_LIVEDEC,
    input  logic       SC_GAMESTATUS_LEVELINC,
    input  logic [7:0] SC_GAMESTATUS_LEVELOR,
    input  logic [2:0] SC_GAMESTATUS_RESETLEVEL,
    input  logic [3:0] SC_GAMESTATUS_NEXTLEVEL,
    output logic [3:0] SC_GAMESTATUS_LIVECOUNT,
    output logic [3:0] SC_GAMESTATUS_LEVELCOUNT,
    output logic [7:0] SC_GAMESTATUS_HOUSES,
    output logic [1:0] SC_GAMESTATUS_SPEEDSEL,
    output logic       SC_GAMESTATUS_RESPAWN,
    output logic       SC_GAMESTATUS_GAMEOVER,
    output logic       SC_GAMESTATUS_GAMEWIN
);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_OVER    = 2'd2,
        ST_WIN     = 2'd3
    } state_t;

    localparam logic [3:0]           LIVES_RST = 4'(INIT_LIVES);
    localparam logic [3:0]           LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [HOLDOFF_W-1:0] HOLD_LD   = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           lives_q, lives_d;
    logic [3:0]           level_q, level_d;
    logic [7:0]           houses_q, houses_d;
    logic [1:0]           speed_q, speed_d;
    logic                 respawn_q, respawn_d;
    logic                 over_q, over_d;
    logic                 win_q, win_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic                 live_acc_s;

    // Next-state logic: lose/win codes pre-empt everything, then level pass,
    // then life loss (only accepted outside hold-off), then the houses load.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        houses_d   = houses_q;
        respawn_d  = 1'b0;
        over_d     = over_q;
        win_d      = win_q;
        hold_d     = hold_q;
        live_acc_s = 1'b0;
        case (state_q)
            ST_PLAY, ST_HOLDOFF: begin
                if (SC_GAMESTATUS_RESETLEVEL == 3'd2) begin
                    state_d = ST_OVER;
                    over_d  = 1'b1;
                end else if (SC_GAMESTATUS_NEXTLEVEL == 4'd3) begin
                    state_d = ST_WIN;
                    win_d   = 1'b1;
                end else begin
                    live_acc_s = SC_GAMESTATUS_LIVEDEC && (state_q == ST_PLAY);
                    if (SC_GAMESTATUS_LEVELINC) begin
                        if (level_q < LEVEL_MAX) begin
                            level_d = level_q + 4'd1;
                        end else begin
                            level_d = level_q;
                        end
                        houses_d  = 8'h00;
                        respawn_d = 1'b1;
                    end else if (live_acc_s) begin
                        // A life loss takes the cycle; houses keep their value.
                        houses_d = houses_q;
                    end else begin
                        houses_d = SC_GAMESTATUS_LEVELOR;
                    end
                    if (live_acc_s) begin
                        if (lives_q != 4'd0) begin
                            lives_d = lives_q - 4'd1;
                        end else begin
                            lives_d = 4'd0;
                        end
                        respawn_d = 1'b1;
                        hold_d    = HOLD_LD;
                        state_d   = ST_HOLDOFF;
                    end else if (state_q == ST_HOLDOFF) begin
                        if (hold_q == {HOLDOFF_W{1'b0}}) begin
                            state_d = ST_PLAY;
                        end else begin
                            hold_d = hold_q - {{(HOLDOFF_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_OVER, ST_WIN: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
        speed_d = level_d[1:0];
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge SC_GAMESTATUS_CLOCK_50 or posedge SC_GAMESTATUS_RESET_InHigh) begin
        if (SC_GAMESTATUS_RESET_InHigh) begin
            state_q   <= ST_PLAY;
            lives_q   <= LIVES_RST;
            level_q   <= 4'd0;
            houses_q  <= 8'h00;
            speed_q   <= 2'd0;
            respawn_q <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            hold_q    <= {HOLDOFF_W{1'b0}};
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            houses_q  <= houses_d;
            speed_q   <= speed_d;
            respawn_q <= respawn_d;
            over_q    <= over_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
        end
    end

    assign SC_GAMESTATUS_LIVECOUNT  = lives_q;
    assign SC_GAMESTATUS_LEVELCOUNT = level_q;
    assign SC_GAMESTATUS_HOUSES     = houses_q;
    assign SC_GAMESTATUS_SPEEDSEL   = speed_q;
    assign SC_GAMESTATUS_RESPAWN    = respawn_q;
    assign SC_GAMESTATUS_GAMEOVER   = over_q;
    assign SC_GAMESTATUS_GAMEWIN    = win_q;

endmodule

// File: tb/tb_sc_game_status.sv
// -----------------------------------------------------------------------------
// tb_sc_game_status
// Directed test of sc_game_status with a short hold-off (4 cycles).
// -----------------------------------------------------------------------------
module tb_sc_game_status;

    logic       clk;
    logic       rst;
    logic       livedec;
    logic       levelinc;
    logic [7:0] levelor;
    logic [2:0] resetlevel;
    logic [3:0] nextlevel;
    logic [3:0] livecount;
    logic [3:0] levelcount;
    logic [7:0] houses;
    logic [1:0] speedsel;
    logic       respawn;
    logic       gameover;
    logic       gamewin;

    int total = 0;
    int bad   = 0;

    sc_game_status #(
        .INIT_LIVES     (3),
        .MAX_LEVEL      (3),
        .HOLDOFF_CYCLES (4),
        .HOLDOFF_W      (20)
    ) dut (
        .SC_GAMESTATUS_CLOCK_50     (clk),
        .SC_GAMESTATUS_RESET_InHigh (rst),
        .SC_GAMESTATUS_LIVEDEC      (livedec),
        .SC_GAMESTATUS_LEVELINC     (levelinc),
        .SC_GAMESTATUS_LEVELOR      (levelor),
        .SC_GAMESTATUS_RESETLEVEL   (resetlevel),
        .SC_GAMESTATUS_NEXTLEVEL    (nextlevel),
        .SC_GAMESTATUS_LIVECOUNT    (livecount),
        .SC_GAMESTATUS_LEVELCOUNT   (levelcount),
        .SC_GAMESTATUS_HOUSES       (houses),
        .SC_GAMESTATUS_SPEEDSEL     (speedsel),
        .SC_GAMESTATUS_RESPAWN      (respawn),
        .SC_GAMESTATUS_GAMEOVER     (gameover),
        .SC_GAMESTATUS_GAMEWIN      (gamewin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output against one expected snapshot.
    task automatic chk_all(input string tag, input logic [3:0] e_lives, input logic [3:0] e_level,
                           input logic [7:0] e_houses, input logic [1:0] e_speed,
                           input logic e_resp, input logic e_over, input logic e_win);
        chk({tag, ".lives"},   {28'd0, livecount},  {28'd0, e_lives});
        chk({tag, ".level"},   {28'd0, levelcount}, {28'd0, e_level});
        chk({tag, ".houses"},  {24'd0, houses},     {24'd0, e_houses});
        chk({tag, ".speed"},   {30'd0, speedsel},   {30'd0, e_speed});
        chk({tag, ".respawn"}, {31'd0, respawn},    {31'd0, e_resp});
        chk({tag, ".over"},    {31'd0, gameover},   {31'd0, e_over});
        chk({tag, ".win"},     {31'd0, gamewin},    {31'd0, e_win});
    endtask

    initial begin
        rst        = 1'b1;
        livedec    = 1'b0;
        levelinc   = 1'b0;
        levelor    = 8'h00;
        resetlevel = 3'd0;
        nextlevel  = 4'd0;
        step();
        step();
        rst = 1'b0;

        // 1. reset values
        chk_all("reset", 4'd3, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("idle", 4'd3, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

        // 2. houses follow LEVELOR one cycle later
        levelor = 8'h05;
        step();
        chk_all("levelor1", 4'd3, 4'd0, 8'h05, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("levelor3", {24'd0, houses}, 32'h05);

        // 3. life loss, then LIVEDEC held through the 4-cycle hold-off
        livedec = 1'b1;
        step();
        chk_all("life1", 4'd2, 4'd0, 8'h05, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold.lives", {28'd0, livecount}, 32'd2);
            chk("hold.respawn", {31'd0, respawn}, 32'd0);
        end
        // hold-off has expired: the next LIVEDEC counts again
        step();
        chk_all("life2", 4'd1, 4'd0, 8'h05, 2'd0, 1'b1, 1'b0, 1'b0);
        livedec = 1'b0;

        // 4. level pass clears full houses (acts during hold-off too)
        levelor = 8'hFF;
        step();
        chk("houses_ff", {24'd0, houses}, 32'hFF);
        levelinc = 1'b1;
        step();
        chk_all("level1", 4'd1, 4'd1, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
        levelinc = 1'b0;
        step();
        chk_all("level1b", 4'd1, 4'd1, 8'hFF, 2'd1, 1'b0, 1'b0, 1'b0);
        levelinc = 1'b1;
        step();
        chk_all("level2", 4'd1, 4'd2, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("level3", 4'd1, 4'd3, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("level_sat", 4'd1, 4'd3, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0);
        levelinc = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // simultaneous LIVEDEC and LEVELINC in PLAY
        livedec  = 1'b1;
        levelinc = 1'b1;
        step();
        chk_all("both", 4'd0, 4'd3, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0);
        livedec  = 1'b0;
        levelinc = 1'b0;
        step();
        chk("both.respawn_once", {31'd0, respawn}, 32'd0);
        for (int i = 0; i < 6; i++) step();

        // LIVEDEC with zero lives: stays 0, still respawns
        livedec = 1'b1;
        step();
        chk_all("lives_zero", 4'd0, 4'd3, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0);
        livedec = 1'b0;

        // 5. game lost, then everything frozen
        resetlevel = 3'd2;
        step();
        chk_all("over", 4'd0, 4'd3, 8'hFF, 2'd3, 1'b0, 1'b1, 1'b0);
        resetlevel = 3'd0;
        levelor    = 8'h12;
        livedec    = 1'b1;
        levelinc   = 1'b1;
        step();
        step();
        chk_all("over_frozen", 4'd0, 4'd3, 8'hFF, 2'd3, 1'b0, 1'b1, 1'b0);
        livedec  = 1'b0;
        levelinc = 1'b0;
        // asynchronous reset takes effect without a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'd3, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst     = 1'b0;
        levelor = 8'h00;
        step();

        // 6. win takes priority over a simultaneous life loss
        nextlevel = 4'd3;
        livedec   = 1'b1;
        step();
        chk_all("win", 4'd3, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        nextlevel = 4'd0;
        livedec   = 1'b0;
        levelinc  = 1'b1;
        step();
        chk_all("win_frozen", 4'd3, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        levelinc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
